// File: rtl/lm_event_arbiter.sv
// lm_event_arbiter: log-manager front end. Four event sources (CM errors,
// UART errors, configuration changes, debug UART data) are captured into
// one-entry holding registers and shared round-robin over one byte channel.
// Each grant is sent as a two-byte frame: header, then payload.
//
// Handshake: a byte transfers on a rising edge where out_valid and out_ready
// are both 1; while out_valid is 1 and out_ready is 0, out_data is held.
module lm_event_arbiter #(
    parameter int WIDTH_UART_DATA     = 8,
    parameter int WIDTH_VGA_ERROR     = 3,
    parameter int WIDTH_UART_ERROR    = 2,
    parameter int WIDTH_CONFIGURATION = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           UART_data_debug_switch,
    input  logic [WIDTH_UART_DATA-1:0]     UART_data,
    input  logic                           UART_data_valid,
    input  logic [WIDTH_VGA_ERROR-1:0]     CM_errors,
    input  logic                           CM_errors_valid,
    input  logic [WIDTH_UART_ERROR-1:0]    UART_errors,
    input  logic                           UART_errors_valid,
    input  logic [WIDTH_CONFIGURATION-1:0] config_notification,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [1:0]                     state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    state_e                         state_q;
    logic                           out_valid_q;
    logic [7:0]                     out_data_q;
    logic [7:0]                     pay_q;
    logic [1:0]                     rr_q;
    logic [WIDTH_CONFIGURATION-1:0] cfg_prev_q;

    logic [3:0]      pend_q, pend_d;
    logic [3:0]      ovf_q,  ovf_d;
    logic [3:0][7:0] data_q, data_d;

    logic [3:0]      cap_vld;
    logic [3:0][7:0] cap_data;
    logic            gnt_found;
    logic [1:0]      gnt_tag;
    logic [1:0]      idx;
    logic [3:0]      clr;

    // Per-source capture strobes and zero-extended payloads, indexed by tag.
    always_comb begin
        cap_vld[0]  = CM_errors_valid;
        cap_vld[1]  = UART_errors_valid;
        cap_vld[2]  = (config_notification != cfg_prev_q);
        cap_vld[3]  = UART_data_valid & UART_data_debug_switch;
        cap_data[0] = 8'(CM_errors);
        cap_data[1] = 8'(UART_errors);
        cap_data[2] = 8'(config_notification);
        cap_data[3] = 8'(UART_data);
    end

    // Round-robin search: first pending source at or above rr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_tag   = 2'd0;
        idx       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_tag   = idx;
            end
        end
        clr = 4'b0000;
        if (state_q == ST_IDLE && gnt_found) begin
            clr[gnt_tag] = 1'b1;
        end
    end

    // Holding-register next state: grant clears, a capture in the same cycle
    // wins, a capture onto a still-pending entry only marks overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        data_d = data_q;
        for (int i = 0; i < 4; i++) begin
            if (clr[i]) begin
                pend_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
            end
            if (cap_vld[i]) begin
                if (pend_q[i] && !clr[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    data_d[i] = cap_data[i];
                    pend_d[i] = 1'b1;
                end
            end
        end
        // Debug data is discarded entirely while forwarding is switched off.
        if (!UART_data_debug_switch) begin
            pend_d[3] = 1'b0;
            ovf_d[3]  = 1'b0;
        end
    end

    // Holding registers and the previous configuration word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            ovf_q      <= '0;
            data_q     <= '0;
            cfg_prev_q <= '0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
            cfg_prev_q <= config_notification;
        end
    end

    // Frame FSM with registered outputs: IDLE grants, HDR and PAY present bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            pay_q       <= 8'h00;
            rr_q        <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        out_data_q  <= {1'b1, gnt_tag, ovf_q[gnt_tag], 4'b0000};
                        out_valid_q <= 1'b1;
                        pay_q       <= data_q[gnt_tag];
                        rr_q        <= gnt_tag + 2'd1;
                        state_q     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        out_data_q <= pay_q;
                        state_q    <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lm_event_arbiter.sv
// Bench for lm_event_arbiter: directed events, expected frame bytes queued
// by the stimulus, popped and compared by an independent output monitor.
module tb_lm_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw = 1'b1;
    logic [7:0] uart_data = '0;
    logic       uart_data_valid = 1'b0;
    logic [2:0] cm_errors = '0;
    logic       cm_errors_valid = 1'b0;
    logic [1:0] uart_errors = '0;
    logic       uart_errors_valid = 1'b0;
    logic [3:0] cfg = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    lm_event_arbiter dut (
        .clk                    (clk),
        .rst                    (rst),
        .UART_data_debug_switch (sw),
        .UART_data              (uart_data),
        .UART_data_valid        (uart_data_valid),
        .CM_errors              (cm_errors),
        .CM_errors_valid        (cm_errors_valid),
        .UART_errors            (uart_errors),
        .UART_errors_valid      (uart_errors_valid),
        .config_notification    (cfg),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .busy                   (busy),
        .state_dbg_o            (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // monitor: every accepted byte is compared with the head of the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got 0x%02h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL frame_byte: got 0x%02h expected 0x%02h", out_data, e);
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        cm_errors_valid = 1'b0;
        uart_errors_valid = 1'b0;
        uart_data_valid = 1'b0;
        cfg = 4'h0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic strobe(input logic c_v, input logic [2:0] c_d,
                          input logic u_v, input logic [1:0] u_d,
                          input logic d_v, input logic [7:0] d_d);
        @(posedge clk);
        #1;
        cm_errors_valid = c_v;    cm_errors = c_d;
        uart_errors_valid = u_v;  uart_errors = u_d;
        uart_data_valid = d_v;    uart_data = d_d;
        @(posedge clk);
        #1;
        cm_errors_valid = 1'b0;
        uart_errors_valid = 1'b0;
        uart_data_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got out_valid=0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !out_valid) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got %0d bytes outstanding expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        // reset values
        #2;
        check("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        do_reset();

        // single CM event, busy timing
        exp_q.push_back(8'h80); exp_q.push_back(8'h05);
        strobe(1, 3'b101, 0, 2'b00, 0, 8'h00);
        @(negedge clk); check("busy_pend_cycle", {7'd0, busy}, 8'h00);
        @(negedge clk); check("busy_hdr", {7'd0, busy}, 8'h01);
        @(negedge clk); check("busy_pay", {7'd0, busy}, 8'h01);
        @(negedge clk); check("busy_after", {7'd0, busy}, 8'h00);
        drain("cm_single");

        // all four sources together, rr = 0 after reset
        do_reset();
        sw = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h03);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h03);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hA5);
        @(posedge clk); #1 cfg = 4'h3;
        cm_errors_valid = 1'b1; cm_errors = 3'b010;
        uart_errors_valid = 1'b1; uart_errors = 2'b11;
        uart_data_valid = 1'b1; uart_data = 8'hA5;
        @(posedge clk); #1;
        cm_errors_valid = 1'b0; uart_errors_valid = 1'b0; uart_data_valid = 1'b0;
        drain("all_four");

        // UART overflow during a stalled CM frame
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(8'h80); exp_q.push_back(8'h01);
        exp_q.push_back(8'hB0); exp_q.push_back(8'h01);
        strobe(1, 3'b001, 0, 2'b00, 0, 8'h00);
        wait_valid("stall_hdr");
        strobe(0, 3'b000, 1, 2'b01, 0, 8'h00);
        strobe(0, 3'b000, 1, 2'b10, 0, 8'h00);
        @(negedge clk); check("stall_hold_data", out_data, 8'h80);
        check("stall_hold_valid", {7'd0, out_valid}, 8'h01);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("ovf_frame");
        exp_q.push_back(8'hA0); exp_q.push_back(8'h03);
        strobe(0, 3'b000, 1, 2'b11, 0, 8'h00);
        drain("ovf_cleared");

        // configuration change, then a steady level
        do_reset();
        exp_q.push_back(8'hC0); exp_q.push_back(8'h09);
        @(posedge clk); #1 cfg = 4'h9;
        drain("cfg_change");
        repeat (10) @(negedge clk);
        check("cfg_steady_valid", {7'd0, out_valid}, 8'h00);

        // debug data gated by the switch
        sw = 1'b0;
        strobe(0, 3'b000, 0, 2'b00, 1, 8'h33);
        strobe(0, 3'b000, 0, 2'b00, 1, 8'h44);
        repeat (10) @(negedge clk);
        check("sw_off_valid", {7'd0, out_valid}, 8'h00);
        check("sw_off_busy", {7'd0, busy}, 8'h00);
        @(posedge clk); #1 sw = 1'b1;
        exp_q.push_back(8'hE0); exp_q.push_back(8'h5A);
        strobe(0, 3'b000, 0, 2'b00, 1, 8'h5A);
        drain("sw_on_data");

        // reset while the payload is presented
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(8'h80);
        strobe(1, 3'b111, 0, 2'b00, 0, 8'h00);
        wait_valid("rst_hdr");
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("pay_state", {6'd0, state_dbg}, 8'h02);
        check("pay_data", out_data, 8'h07);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", {7'd0, out_valid}, 8'h00);
        check("rst_mid_busy", {7'd0, busy}, 8'h00);
        check("rst_mid_hdr_taken", 8'(exp_q.size()), 8'h00);
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back(8'h05);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h02);
        strobe(1, 3'b101, 1, 2'b10, 0, 8'h00);
        drain("after_rst_rr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
